// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: per-channel off / on / blink / PWM modes behind a one-cycle write port.
// Optional breathe mode (triangle-ramped PWM level) is built only when LED_BREATHE_EN is defined.
module led_pwm_ctrl #(
   parameter int          NUM_CH         = 2,
   parameter int          CH_W           = 4,
   parameter logic [31:0] BLINK_INTERVAL = 32'h01FF_FFFF,
   parameter int          PWM_W          = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [CH_W-1:0]   wr_ch_i,
   input  logic [2:0]        wr_mode_i,
   input  logic [PWM_W-1:0]  wr_duty_i,
   output logic [NUM_CH-1:0] led_out_o,
   output logic              tick_out_o
);

   typedef enum logic [2:0] {
      MODE_OFF     = 3'b000,
      MODE_ON      = 3'b001,
      MODE_BLINK   = 3'b010,
      MODE_PWM     = 3'b011,
      MODE_BREATHE = 3'b100
   } mode_e;

   localparam logic [PWM_W-1:0] PWM_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

   logic [31:0]       pre_cnt_q, pre_cnt_d;
   logic              blink_phase_q, blink_phase_d;
   logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic [2:0]        mode_q [NUM_CH];
   logic [2:0]        mode_d [NUM_CH];
   logic [PWM_W-1:0]  duty_q [NUM_CH];
   logic [PWM_W-1:0]  duty_d [NUM_CH];
   logic [NUM_CH-1:0] led_q, led_d;
   logic              tick_q, tick_d;
   logic              pre_wrap, pwm_wrap;
`ifdef LED_BREATHE_EN
   // dir: 0 = ramping up, 1 = ramping down
   logic [PWM_W-1:0]  lvl_q [NUM_CH];
   logic [PWM_W-1:0]  lvl_d [NUM_CH];
   logic              dir_q [NUM_CH];
   logic              dir_d [NUM_CH];
`endif

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pre_wrap      = (pre_cnt_q == BLINK_INTERVAL);
      pre_cnt_d     = pre_wrap ? '0 : pre_cnt_q + 32'd1;
      tick_d        = pre_wrap;
      blink_phase_d = blink_phase_q ^ pre_wrap;
      pwm_wrap      = (pwm_cnt_q == PWM_LAST);
      pwm_cnt_d     = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
      mode_d        = mode_q;
      duty_d        = duty_q;
      led_d         = '0;
`ifdef LED_BREATHE_EN
      lvl_d         = lvl_q;
      dir_d         = dir_q;
`endif
      for (int n = 0; n < NUM_CH; n++) begin
         // Writes to channels >= NUM_CH match no iteration and are dropped.
         if (wr_en_i && (wr_ch_i == CH_W'(n))) begin
            mode_d[n] = wr_mode_i;
            duty_d[n] = wr_duty_i;
         end
`ifdef LED_BREATHE_EN
         if (wr_en_i && (wr_ch_i == CH_W'(n)) && (wr_mode_i == MODE_BREATHE)) begin
            lvl_d[n] = '0;
            dir_d[n] = 1'b0;
         end else if ((mode_q[n] == MODE_BREATHE) && pwm_wrap) begin
            if (!dir_q[n]) begin
               lvl_d[n] = lvl_q[n] + 1'b1;
               if (lvl_q[n] == PWM_LAST) dir_d[n] = 1'b1;
            end else begin
               lvl_d[n] = lvl_q[n] - 1'b1;
               if (lvl_q[n] == PWM_W'(1)) dir_d[n] = 1'b0;
            end
         end
`endif
         case (mode_q[n])
            MODE_ON:      led_d[n] = 1'b1;
            MODE_BLINK:   led_d[n] = blink_phase_q;
            MODE_PWM:     led_d[n] = (pwm_cnt_q < duty_q[n]);
`ifdef LED_BREATHE_EN
            MODE_BREATHE: led_d[n] = (pwm_cnt_q < lvl_q[n]);
`endif
            default:      led_d[n] = 1'b0;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_cnt_q     <= '0;
         blink_phase_q <= 1'b0;
         pwm_cnt_q     <= '0;
         // NOTE: the config arrays are reset too; they are flops, not a RAM, and a defined power-up mode is required.
         mode_q        <= '{default: '0};
         duty_q        <= '{default: '0};
         led_q         <= '0;
         tick_q        <= 1'b0;
`ifdef LED_BREATHE_EN
         lvl_q         <= '{default: '0};
         dir_q         <= '{default: 1'b0};
`endif
      end else begin
         pre_cnt_q     <= pre_cnt_d;
         blink_phase_q <= blink_phase_d;
         pwm_cnt_q     <= pwm_cnt_d;
         mode_q        <= mode_d;
         duty_q        <= duty_d;
         led_q         <= led_d;
         tick_q        <= tick_d;
`ifdef LED_BREATHE_EN
         lvl_q         <= lvl_d;
         dir_q         <= dir_d;
`endif
      end
   end

   assign led_out_o  = led_q;
   assign tick_out_o = tick_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl (NUM_CH=2, BLINK_INTERVAL=3, PWM_W=3).
// A cycle model pushes the expected {led_out, tick_out} at each edge; scenario tasks pop and compare.
module tb_led_pwm_ctrl;

   localparam int NUM_CH = 2;
   localparam int CH_W   = 4;
   localparam int BI     = 3;
   localparam int PWM_W  = 3;
   localparam int PER    = 7;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_en = 1'b0;
   logic [CH_W-1:0]   wr_ch = '0;
   logic [2:0]        wr_mode = '0;
   logic [PWM_W-1:0]  wr_duty = '0;
   logic [NUM_CH-1:0] led_out;
   logic              tick_out;

   int errors = 0;
   int checks = 0;
   logic [2:0] exp_q [$];
   logic [2:0] exp, got;

   // Model state: edges since reset, per-channel config, breathe step count since the mode-100 write.
   int         n_m;
   logic [2:0] m_mode [NUM_CH];
   logic [2:0] m_duty [NUM_CH];
   int         m_step [NUM_CH];

   led_pwm_ctrl #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .BLINK_INTERVAL(32'(BI)), .PWM_W(PWM_W)
   ) dut (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_ch_i(wr_ch),
      .wr_mode_i(wr_mode), .wr_duty_i(wr_duty),
      .led_out_o(led_out), .tick_out_o(tick_out)
   );

   always #5 clk = ~clk;

   // Expected outputs after the coming edge, from model state before it.
   function automatic logic [2:0] model_out();
      logic [1:0] led;
      int pwm, phase, t, lvl;
      pwm   = n_m % PER;
      phase = (n_m / (BI + 1)) % 2;
      led   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         t   = m_step[c] % (2 * PER);
         lvl = (t <= PER) ? t : 2 * PER - t;
         case (m_mode[c])
            3'd1: led[c] = 1'b1;
            3'd2: led[c] = phase[0];
            3'd3: led[c] = (pwm < int'(m_duty[c]));
`ifdef LED_BREATHE_EN
            3'd4: led[c] = (pwm < lvl);
`endif
            default: led[c] = 1'b0;
         endcase
      end
      return {led, (n_m % (BI + 1)) == BI};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         exp_q.push_back(3'b000);
         n_m    <= 0;
         m_mode <= '{default: '0};
         m_duty <= '{default: '0};
         m_step <= '{default: 0};
      end else begin
         exp_q.push_back(model_out());
         n_m <= n_m + 1;
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && (int'(wr_ch) == c)) begin
               m_mode[c] <= wr_mode;
               m_duty[c] <= wr_duty;
               if (wr_mode == 3'd4) m_step[c] <= 0;
            end else if ((m_mode[c] == 3'd4) && (n_m % PER == PER - 1)) begin
               m_step[c] <= m_step[c] + 1;
            end
         end
      end
   end

   task automatic drive(input logic en, input int ch, input logic [2:0] mode, input logic [2:0] duty);
      wr_en   = en;
      wr_ch   = CH_W'(ch);
      wr_mode = mode;
      wr_duty = duty;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         checks++;
         got = {led_out, tick_out};
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset[%0d]: led=%b tick=%b, expected led=%b tick=%b", i, got[2:1], got[0], exp[2:1], exp[0]);
         end
         if (i == 2) rst = 1'b0;
      end
   endtask

   task automatic test_on_off();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         got = {led_out, tick_out};
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
         if (got !== exp) begin
            errors++;
            $display("FAIL on_off[%0d]: led=%b tick=%b, expected led=%b tick=%b", i, got[2:1], got[0], exp[2:1], exp[0]);
         end
         drive(i == 0 || i == 5, 0, (i == 0) ? 3'd1 : 3'd0, 3'd0);
      end
   endtask

   task automatic test_blink();
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         checks++;
         got = {led_out, tick_out};
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
         if (got !== exp) begin
            errors++;
            $display("FAIL blink[%0d]: led=%b tick=%b, expected led=%b tick=%b", i, got[2:1], got[0], exp[2:1], exp[0]);
         end
         drive(i == 0 || i == 9, (i == 0) ? 1 : 0, 3'd2, 3'd0);
      end
   endtask

   task automatic test_pwm();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++;
         got = {led_out, tick_out};
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
         if (got !== exp) begin
            errors++;
            $display("FAIL pwm[%0d]: led=%b tick=%b, expected led=%b tick=%b", i, got[2:1], got[0], exp[2:1], exp[0]);
         end
         drive(i == 0 || i == 16 || i == 24, 0, 3'd3, (i == 0) ? 3'd3 : (i == 16) ? 3'd0 : 3'd7);
      end
   endtask

   // Bad channel write, reset during blink-high with a simultaneous write, then restart.
   task automatic test_bad_ch_reset();
      int rst_at = -1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         checks++;
         got = {led_out, tick_out};
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
         if (got !== exp) begin
            errors++;
            $display("FAIL bad_ch_reset[%0d]: led=%b tick=%b, expected led=%b tick=%b", i, got[2:1], got[0], exp[2:1], exp[0]);
         end
         rst = 1'b0;
         drive(i == 0, 2, 3'd1, 3'd7);
         if (rst_at < 0 && i >= 2 && exp[2] === 1'b1) begin
            rst_at = i;
            rst = 1'b1;
            drive(1'b1, 0, 3'd1, 3'd0);
         end
      end
      checks++;
      if (rst_at < 0) begin
         errors++;
         $display("FAIL bad_ch_reset_window: blink-high phase seen=0, required=1");
      end
   endtask

   task automatic test_breathe();
      for (int i = 0; i < 2 * PER * PER + 10; i++) begin
         @(negedge clk);
         checks++;
         got = {led_out, tick_out};
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
         if (got !== exp) begin
            errors++;
            $display("FAIL breathe[%0d]: led=%b tick=%b, expected led=%b tick=%b", i, got[2:1], got[0], exp[2:1], exp[0]);
         end
         drive(i == 0, 0, 3'd4, 3'd5);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] modes [8] = '{3'd1, 3'd3, 3'd2, 3'd5, 3'd1, 3'd0, 3'd3, 3'd7};
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         got = {led_out, tick_out};
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
         if (got !== exp) begin
            errors++;
            $display("FAIL back_to_back[%0d]: led=%b tick=%b, expected led=%b tick=%b", i, got[2:1], got[0], exp[2:1], exp[0]);
         end
         if (i < 12) drive(1'b1, (i % 3 == 2) ? 15 : i % 2, modes[i % 8], 3'(i));
         else        drive(1'b0, 0, 3'd0, 3'd0);
      end
   endtask

   initial begin
      test_reset();
      test_on_off();
      test_blink();
      test_pwm();
      test_bad_ch_reset();
      test_breathe();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
